// File: rtl/cache_fill_if.sv
// Bundles the miss-request, memory-return and data/tag-array write signals of the fill sequencer.
// master: the fill controller; slave: the surrounding cache and memory logic.
interface cache_fill_if;
  logic        miss_detected;
  logic [15:0] miss_addr;
  logic [1:0]  miss_way;
  logic        mem_data_valid;
  logic [15:0] mem_data_in;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        fsm_busy;
  logic        write_data_array;
  logic [31:0] data_block_en_0;
  logic [31:0] data_block_en_1;
  logic [31:0] data_block_en_2;
  logic [31:0] data_block_en_3;
  logic [7:0]  data_word_en;
  logic [15:0] data_out;
  logic        write_tag_array;
  logic        fill_done;
  logic        fill_error;

  modport master (
    input  miss_detected, miss_addr, miss_way, mem_data_valid, mem_data_in,
    output mem_en, mem_addr, fsm_busy, write_data_array,
    output data_block_en_0, data_block_en_1, data_block_en_2, data_block_en_3,
    output data_word_en, data_out, write_tag_array, fill_done, fill_error
  );

  modport slave (
    output miss_detected, miss_addr, miss_way, mem_data_valid, mem_data_in,
    input  mem_en, mem_addr, fsm_busy, write_data_array,
    input  data_block_en_0, data_block_en_1, data_block_en_2, data_block_en_3,
    input  data_word_en, data_out, write_tag_array, fill_done, fill_error
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Miss-fill sequencer: requests the 8 words of a missing block and writes returns into the victim way.
// Define CRITICAL_WORD_FIRST_EN to start the fill at the missed word and wrap modulo 8.
module cache_fill_ctrl #(
  parameter int unsigned FILL_TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst,
  cache_fill_if.master bus
);

  localparam int unsigned TmoW = $clog2(FILL_TIMEOUT) + 1;

  typedef enum logic {StIdle, StFill} state_e;

  state_e            state_q, state_d;
  logic [6:0]        tag_q, tag_d;
  logic [4:0]        set_q, set_d;
  logic [2:0]        start_q, start_d;
  logic [1:0]        way_q, way_d;
  logic [2:0]        req_cnt_q, req_cnt_d;
  logic [2:0]        ret_cnt_q, ret_cnt_d;
  logic              req_done_q, req_done_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic [2:0]        req_word, ret_word;
  logic [31:0]       blk_en;
  logic              timeout;
  logic              unused_addr;

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_d     = bus.miss_detected && (state_q == StIdle) ? bus.miss_addr[3:1] : start_q;
  assign unused_addr = bus.miss_addr[0];
`else
  assign start_d     = 3'd0;
  assign unused_addr = ^bus.miss_addr[3:0];
`endif

  assign req_word = start_q + req_cnt_q;
  assign ret_word = start_q + ret_cnt_q;
  assign timeout  = (state_q == StFill) && (tmo_cnt_q == TmoW'(FILL_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tag_q      <= '0;
      set_q      <= '0;
      start_q    <= '0;
      way_q      <= '0;
      req_cnt_q  <= '0;
      ret_cnt_q  <= '0;
      req_done_q <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      set_q      <= set_d;
      start_q    <= start_d;
      way_q      <= way_d;
      req_cnt_q  <= req_cnt_d;
      ret_cnt_q  <= ret_cnt_d;
      req_done_q <= req_done_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    tag_d                = tag_q;
    set_d                = set_q;
    way_d                = way_q;
    req_cnt_d            = req_cnt_q;
    ret_cnt_d            = ret_cnt_q;
    req_done_d           = req_done_q;
    tmo_cnt_d            = tmo_cnt_q;
    bus.mem_en           = 1'b0;
    bus.mem_addr         = '0;
    bus.fsm_busy         = 1'b0;
    bus.write_data_array = 1'b0;
    bus.data_word_en     = '0;
    bus.data_out         = '0;
    bus.write_tag_array  = 1'b0;
    bus.fill_done        = 1'b0;
    bus.fill_error       = 1'b0;
    blk_en               = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.miss_detected) begin
          state_d    = StFill;
          tag_d      = bus.miss_addr[15:9];
          set_d      = bus.miss_addr[8:4];
          way_d      = bus.miss_way;
          req_cnt_d  = '0;
          ret_cnt_d  = '0;
          req_done_d = 1'b0;
          tmo_cnt_d  = '0;
        end
      end
      StFill: begin
        bus.fsm_busy = 1'b1;
        tmo_cnt_d    = tmo_cnt_q + 1'b1;
        // req_cnt wraps after the eighth request; req_done stops further issue.
        if (!req_done_q) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = {tag_q, set_q, req_word, 1'b0};
          req_cnt_d    = req_cnt_q + 1'b1;
          req_done_d   = (req_cnt_q == 3'd7);
        end
        if (bus.mem_data_valid) begin
          bus.write_data_array = 1'b1;
          bus.data_word_en     = 8'b1 << ret_word;
          bus.data_out         = bus.mem_data_in;
          blk_en               = 32'b1 << set_q;
          ret_cnt_d            = ret_cnt_q + 1'b1;
          if ((ret_cnt_q == 3'd7) && !timeout) begin
            bus.write_tag_array = 1'b1;
            bus.fill_done       = 1'b1;
            state_d             = StIdle;
          end
        end
        // A word landing on the timeout cycle is written but never committed.
        if (timeout) begin
          bus.fill_error = 1'b1;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.data_block_en_0 = (way_q == 2'd0) ? blk_en : '0;
  assign bus.data_block_en_1 = (way_q == 2'd1) ? blk_en : '0;
  assign bus.data_block_en_2 = (way_q == 2'd2) ? blk_en : '0;
  assign bus.data_block_en_3 = (way_q == 2'd3) ? blk_en : '0;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: directed scenarios plus randomized fills against
// a closed-form per-cycle model of request, return, commit and timeout behaviour.
module tb_cache_fill_ctrl;

  localparam int Tmo = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  cache_fill_if bus ();

  cache_fill_ctrl #(.FILL_TIMEOUT(Tmo)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_en, input logic [15:0] e_addr,
                               input logic e_busy, input logic e_wr, input logic [127:0] e_blk,
                               input logic [7:0] e_wen, input logic [15:0] e_dout,
                               input logic e_tag, input logic e_done, input logic e_err);
    check({tag, ".mem_en"}, 128'(bus.mem_en), 128'(e_en));
    check({tag, ".mem_addr"}, 128'(bus.mem_addr), 128'(e_addr));
    check({tag, ".busy"}, 128'(bus.fsm_busy), 128'(e_busy));
    check({tag, ".wr"}, 128'(bus.write_data_array), 128'(e_wr));
    check({tag, ".blk_en"}, {bus.data_block_en_3, bus.data_block_en_2, bus.data_block_en_1,
                             bus.data_block_en_0}, e_blk);
    check({tag, ".word_en"}, 128'(bus.data_word_en), 128'(e_wen));
    check({tag, ".data_out"}, 128'(bus.data_out), 128'(e_dout));
    check({tag, ".tag_wr"}, 128'(bus.write_tag_array), 128'(e_tag));
    check({tag, ".done"}, 128'(bus.fill_done), 128'(e_done));
    check({tag, ".error"}, 128'(bus.fill_error), 128'(e_err));
  endtask

  // One miss plus its fill. Memory answers request i at FILL cycle i+lat, for the first nret
  // requests only. rst_cyc > 0 asserts reset in that FILL cycle and abandons the fill.
  task automatic run_fill(input string name, input logic [15:0] addr, input logic [1:0] way,
                          input int lat, input int nret, input bit hold, input bit stray,
                          input int rst_cyc, input logic [15:0] base);
    logic [2:0]   start;
    logic [2:0]   w;
    logic [15:0]  dat;
    logic [127:0] e_blk;
    logic         v;
    int           k;
    int           end_c;
`ifdef CRITICAL_WORD_FIRST_EN
    start = addr[3:1];
`else
    start = 3'd0;
`endif
    end_c = (nret == 8 && 8 + lat < Tmo) ? 8 + lat : Tmo;

    @(negedge clk);
    rst                = 1'b0;
    bus.miss_detected  = 1'b1;
    bus.miss_addr      = addr;
    bus.miss_way       = way;
    bus.mem_data_valid = stray;
    bus.mem_data_in    = 16'($urandom);
    #1;
    check_outputs({name, ".idle"}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      bus.miss_detected  = hold;
      bus.miss_addr      = 16'($urandom);
      bus.miss_way       = 2'($urandom);
      k                  = c - lat - 1;
      v                  = (k >= 0) && (k < nret) && (k < 8);
      dat                = base + 16'(k);
      bus.mem_data_valid = v;
      bus.mem_data_in    = v ? dat : 16'($urandom);
      if (c == rst_cyc) rst = 1'b1;
      #1;
      w     = 3'((int'(start) + c - 1) % 8);
      e_blk = v ? (128'(1) << (int'(way) * 32 + int'(addr[8:4]))) : '0;
      check_outputs($sformatf("%s.c%0d", name, c),
                    c <= 8, (c <= 8) ? {addr[15:4], w, 1'b0} : 16'h0,
                    1'b1, v, e_blk,
                    v ? (8'(1) << ((int'(start) + k) % 8)) : 8'h0,
                    v ? dat : 16'h0,
                    v && k == 7 && c < Tmo, v && k == 7 && c < Tmo, c == Tmo);
      if (c == rst_cyc) break;
    end
  endtask

  initial begin
    bus.miss_detected  = 1'b0;
    bus.miss_addr      = '0;
    bus.miss_way       = '0;
    bus.mem_data_valid = 1'b0;
    bus.mem_data_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    run_fill("basic", 16'h1234, 2'd2, 4, 8, 0, 0, 0, 16'hA000);
    run_fill("cwf", 16'h003A, 2'd1, 3, 8, 0, 0, 0, 16'h1100);
    run_fill("timeout5", 16'h5678, 2'd1, 4, 5, 0, 0, 0, 16'h2200);
    run_fill("tmo_edge", 16'h9ABC, 2'd0, 8, 8, 0, 0, 0, 16'h3300);
    run_fill("ignored", 16'h4444, 2'd3, 2, 8, 1, 1, 0, 16'h4400);
    run_fill("reset3", 16'h7770, 2'd2, 1, 8, 0, 0, 3, 16'h5500);
    run_fill("after_rst", 16'h0ACE, 2'd1, 2, 8, 0, 1, 0, 16'h6600);
    run_fill("b2b_a", 16'h0000, 2'd0, 1, 8, 0, 0, 0, 16'h7700);
    run_fill("b2b_b", 16'h01F0, 2'd3, 1, 8, 0, 0, 0, 16'h8800);

    for (int i = 0; i < 30; i++) begin
      run_fill($sformatf("rnd%0d", i), 16'($urandom), 2'($urandom),
               int'($urandom_range(1, 9)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 8,
               1'($urandom), 1'($urandom), 0, 16'($urandom));
    end

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.miss_detected  = 1'b0;
      bus.mem_data_valid = 1'b1;
      bus.mem_data_in    = 16'($urandom);
      #1;
      check_outputs($sformatf("tail%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
